// File: rtl/ula_arbitro_if.sv
// Bundle of request, response and ALU-side signals for the ula32 arbiter.
// slave = arbiter side, master = requesters + ALU side.
interface ula_arbitro_if #(
   parameter int unsigned LARGURA = 32
);
   logic               req0_valido;
   logic               req0_pronto;
   logic [LARGURA-1:0] req0_a;
   logic [LARGURA-1:0] req0_b;
   logic               req0_cin;
   logic [2:0]         req0_op;

   logic               req1_valido;
   logic               req1_pronto;
   logic [LARGURA-1:0] req1_a;
   logic [LARGURA-1:0] req1_b;
   logic               req1_cin;
   logic [2:0]         req1_op;

   logic               resp0_valido;
   logic               resp0_pronto;
   logic               resp1_valido;
   logic               resp1_pronto;
   logic [LARGURA-1:0] resp_saida;
   logic               resp_cout;
   logic               resp_zero;

   logic [LARGURA-1:0] ula_a;
   logic [LARGURA-1:0] ula_b;
   logic               ula_cin;
   logic [2:0]         ula_controle;
   logic [LARGURA-1:0] ula_saida;
   logic               ula_cout;
   logic               ula_zero;

   logic               ocupado;

   modport slave (
      input  req0_valido, req0_a, req0_b, req0_cin, req0_op,
      input  req1_valido, req1_a, req1_b, req1_cin, req1_op,
      input  resp0_pronto, resp1_pronto,
      input  ula_saida, ula_cout, ula_zero,
      output req0_pronto, req1_pronto,
      output resp0_valido, resp1_valido, resp_saida, resp_cout, resp_zero,
      output ula_a, ula_b, ula_cin, ula_controle,
      output ocupado
   );

   modport master (
      output req0_valido, req0_a, req0_b, req0_cin, req0_op,
      output req1_valido, req1_a, req1_b, req1_cin, req1_op,
      output resp0_pronto, resp1_pronto,
      output ula_saida, ula_cout, ula_zero,
      input  req0_pronto, req1_pronto,
      input  resp0_valido, resp1_valido, resp_saida, resp_cout, resp_zero,
      input  ula_a, ula_b, ula_cin, ula_controle,
      input  ocupado
   );
endinterface

// File: rtl/ula_arbitro.sv
// Round-robin two-requester arbiter/sequencer for the shared ula32 ALU:
// accept, hold ALU inputs CICLOS_ULA cycles, capture flags/result, respond.
module ula_arbitro #(
   parameter int unsigned LARGURA    = 32,
   parameter int unsigned CICLOS_ULA = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   ula_arbitro_if.slave  bus
);

   typedef enum logic [1:0] {
      OCIOSO   = 2'b00,
      EXECUTA  = 2'b01,
      RESPONDE = 2'b10
   } estado_t;

   estado_t            estado;
   estado_t            estado_prox;

   logic               ptr;      // 0: requester 0 favoured on a tie
   logic               id;       // requester owning the in-flight op
   logic               sel;
   logic               aceita;
   logic               captura;
   logic               entrega;
   logic [3:0]         cont;

   logic [LARGURA-1:0] a_r;
   logic [LARGURA-1:0] b_r;
   logic               cin_r;
   logic [2:0]         op_r;
   logic [LARGURA-1:0] saida_r;
   logic               cout_r;
   logic               zero_r;
   logic               v0_r;
   logic               v1_r;

   always_comb begin
      sel = 1'b0;
      if (bus.req0_valido && bus.req1_valido)
         sel = ptr;
      else if (bus.req1_valido)
         sel = 1'b1;
   end

   always_comb begin
      estado_prox     = estado;
      aceita          = 1'b0;
      captura         = 1'b0;
      entrega         = 1'b0;
      bus.req0_pronto = 1'b0;
      bus.req1_pronto = 1'b0;
      case (estado)
         OCIOSO: begin
            bus.req0_pronto = bus.req0_valido && !sel;
            bus.req1_pronto = bus.req1_valido && sel;
            aceita          = bus.req0_valido || bus.req1_valido;
            if (aceita)
               estado_prox = EXECUTA;
         end
         EXECUTA: begin
            if (cont == 4'd0) begin
               captura     = 1'b1;
               estado_prox = RESPONDE;
            end
         end
         RESPONDE: begin
            // only the owner's pronto counts; the other is ignored
            entrega = id ? bus.resp1_pronto : bus.resp0_pronto;
            if (entrega)
               estado_prox = OCIOSO;
         end
         default: estado_prox = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         estado <= OCIOSO;
      else
         estado <= estado_prox;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr     <= 1'b0;
         id      <= 1'b0;
         cont    <= '0;
         a_r     <= '0;
         b_r     <= '0;
         cin_r   <= 1'b0;
         op_r    <= '0;
         saida_r <= '0;
         cout_r  <= 1'b0;
         zero_r  <= 1'b0;
         v0_r    <= 1'b0;
         v1_r    <= 1'b0;
      end else begin
         if (aceita) begin
            id    <= sel;
            a_r   <= sel ? bus.req1_a   : bus.req0_a;
            b_r   <= sel ? bus.req1_b   : bus.req0_b;
            cin_r <= sel ? bus.req1_cin : bus.req0_cin;
            op_r  <= sel ? bus.req1_op  : bus.req0_op;
            cont  <= 4'(CICLOS_ULA - 1);
         end else if (estado == EXECUTA && cont != 4'd0) begin
            cont <= cont - 4'd1;
         end

         if (captura) begin
            saida_r <= bus.ula_saida;
            cout_r  <= bus.ula_cout;
            zero_r  <= bus.ula_zero;
            v0_r    <= !id;
            v1_r    <= id;
         end

         if (entrega) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
            ptr  <= !id;
         end
      end
   end

   assign bus.ula_a        = a_r;
   assign bus.ula_b        = b_r;
   assign bus.ula_cin      = cin_r;
   assign bus.ula_controle = op_r;
   assign bus.resp_saida   = saida_r;
   assign bus.resp_cout    = cout_r;
   assign bus.resp_zero    = zero_r;
   assign bus.resp0_valido = v0_r;
   assign bus.resp1_valido = v1_r;
   assign bus.ocupado      = (estado != OCIOSO);

endmodule

// File: tb/tb_ula_arbitro.sv
// Directed bench for ula_arbitro: vector table on a CICLOS_ULA=1 instance plus
// hand sequences for round-robin, stalls, 3-cycle ALU hold and async reset.
module tb_ula_arbitro;

   logic clk = 1'b0;
   logic rst1_n = 1'b0;
   logic rst3_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ula_arbitro_if #(.LARGURA(32)) bus1 ();
   ula_arbitro_if #(.LARGURA(32)) bus3 ();

   ula_arbitro #(.LARGURA(32), .CICLOS_ULA(1)) dut1 (.clk(clk), .reset_n(rst1_n), .bus(bus1.slave));
   ula_arbitro #(.LARGURA(32), .CICLOS_ULA(3)) dut3 (.clk(clk), .reset_n(rst3_n), .bus(bus3.slave));

   // behavioural ula32 seen by the arbiters: {zero, cout, saida}
   function automatic logic [33:0] ula_mod(input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic [2:0] op);
      logic [32:0] s;
      s = '0;
      case (op)
         3'b000: s = {1'b0, a & b};
         3'b001: s = {1'b0, a | b};
         3'b010: s = {1'b0, a} + {1'b0, b} + 33'(cin);
         3'b011: s = {1'b0, ~(a | b)};
         3'b100: s = {1'b0, a ^ b};
         3'b101: s = {1'b0, ~(a & b)};
         3'b110: s = {1'b0, a} + {1'b0, ~b} + 33'd1;
         default: s = {32'd0, ($signed(a) < $signed(b))};
      endcase
      return {(s[31:0] == 32'd0), s};
   endfunction

   assign {bus1.ula_zero, bus1.ula_cout, bus1.ula_saida} =
      ula_mod(bus1.ula_a, bus1.ula_b, bus1.ula_cin, bus1.ula_controle);
   assign {bus3.ula_zero, bus3.ula_cout, bus3.ula_saida} =
      ula_mod(bus3.ula_a, bus3.ula_b, bus3.ula_cin, bus3.ula_controle);

   typedef struct {
      logic        sel;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] saida;
      logic        cout;
      logic        zero;
   } vec_t;

   vec_t tab[10];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic drive_req(input logic s, input logic v, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic cin);
      if (!s) begin
         bus1.req0_valido = v; bus1.req0_op = op; bus1.req0_a = a;
         bus1.req0_b = b; bus1.req0_cin = cin;
      end else begin
         bus1.req1_valido = v; bus1.req1_op = op; bus1.req1_a = a;
         bus1.req1_b = b; bus1.req1_cin = cin;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int   n;
      logic rv, ro;
      @(negedge clk);
      drive_req(v.sel, 1'b1, v.op, v.a, v.b, v.cin);
      #1;
      chk($sformatf("v%0d_pronto", idx), v.sel ? bus1.req1_pronto : bus1.req0_pronto, 1);
      @(posedge clk);
      @(negedge clk);
      drive_req(v.sel, 1'b0, v.op, v.a, v.b, v.cin);
      chk($sformatf("v%0d_ocupado", idx), bus1.ocupado, 1);
      chk($sformatf("v%0d_controle", idx), bus1.ula_controle, v.op);
      n  = 0;
      rv = v.sel ? bus1.resp1_valido : bus1.resp0_valido;
      while (!rv && n < 20) begin
         @(negedge clk);
         n++;
         rv = v.sel ? bus1.resp1_valido : bus1.resp0_valido;
      end
      chk($sformatf("v%0d_latencia", idx), n, 1);
      ro = v.sel ? bus1.resp0_valido : bus1.resp1_valido;
      chk($sformatf("v%0d_outro_valido", idx), ro, 0);
      chk($sformatf("v%0d_saida", idx), bus1.resp_saida, v.saida);
      chk($sformatf("v%0d_flags", idx), {bus1.resp_cout, bus1.resp_zero}, {v.cout, v.zero});
      if (v.sel) bus1.resp1_pronto = 1'b1; else bus1.resp0_pronto = 1'b1;
      @(negedge clk);
      bus1.resp0_pronto = 1'b0;
      bus1.resp1_pronto = 1'b0;
      chk($sformatf("v%0d_liberado", idx),
          {bus1.ocupado, bus1.resp0_valido, bus1.resp1_valido}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0] = '{1'b0, 3'b010, 32'd5,        32'd7,        1'b0, 32'd12,       1'b0, 1'b0};
      tab[1] = '{1'b1, 3'b110, 32'd9,        32'd9,        1'b0, 32'd0,        1'b1, 1'b1};
      tab[2] = '{1'b0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b0, 1'b0};
      tab[3] = '{1'b1, 3'b001, 32'd1,        32'd2,        1'b0, 32'd3,        1'b0, 1'b0};
      tab[4] = '{1'b0, 3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 32'hF0F00F0F, 1'b0, 1'b0};
      tab[5] = '{1'b1, 3'b011, 32'd0,        32'd0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
      tab[6] = '{1'b0, 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0,        1'b0, 1'b1};
      tab[7] = '{1'b1, 3'b010, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1'b1, 1'b1};
      tab[8] = '{1'b0, 3'b010, 32'd1,        32'd1,        1'b1, 32'd3,        1'b0, 1'b0};
      tab[9] = '{1'b1, 3'b111, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd1,        1'b0, 1'b0};

      drive_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      drive_req(1'b1, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
      bus1.resp0_pronto = 1'b0; bus1.resp1_pronto = 1'b0;
      bus3.req0_valido = 1'b0; bus3.req0_a = '0; bus3.req0_b = '0; bus3.req0_cin = 1'b0; bus3.req0_op = '0;
      bus3.req1_valido = 1'b0; bus3.req1_a = '0; bus3.req1_b = '0; bus3.req1_cin = 1'b0; bus3.req1_op = '0;
      bus3.resp0_pronto = 1'b0; bus3.resp1_pronto = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_estado", {bus1.ocupado, bus1.resp0_valido, bus1.resp1_valido}, 0);
      chk("rst_resp", {bus1.resp_saida, bus1.resp_cout, bus1.resp_zero}, 0);
      chk("rst_ula", {bus1.ula_a, bus1.ula_controle, bus1.ula_cin}, 0);
      rst1_n = 1'b1;
      rst3_n = 1'b1;

      // round-robin: tie after reset goes to req0, then to req1
      @(negedge clk);
      drive_req(1'b0, 1'b1, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);
      drive_req(1'b1, 1'b1, 3'b001, 32'd1, 32'd2, 1'b0);
      #1;
      chk("rr1_pronto", {bus1.req0_pronto, bus1.req1_pronto}, 2'b10);
      @(posedge clk);
      @(negedge clk);
      bus1.req0_valido = 1'b0;
      chk("rr1_exec_pronto1", bus1.req1_pronto, 0);
      chk("rr1_ula_b", bus1.ula_b, 32'hFF00FF00);
      @(negedge clk);
      chk("rr1_resp", {bus1.resp0_valido, bus1.resp1_valido, bus1.resp_saida}, {2'b10, 32'hF000F000});
      bus1.resp0_pronto = 1'b1;
      drive_req(1'b0, 1'b1, 3'b010, 32'd5, 32'd7, 1'b0);
      @(negedge clk);
      bus1.resp0_pronto = 1'b0;
      chk("rr2_ocioso", bus1.ocupado, 0);
      chk("rr2_pronto", {bus1.req0_pronto, bus1.req1_pronto}, 2'b01);
      @(posedge clk);
      @(negedge clk);
      bus1.req1_valido = 1'b0;
      @(negedge clk);
      chk("rr2_resp", {bus1.resp0_valido, bus1.resp1_valido, bus1.resp_saida}, {2'b01, 32'd3});
      chk("rr2_resp_pronto0", bus1.req0_pronto, 0);
      bus1.resp1_pronto = 1'b1;
      @(negedge clk);
      bus1.resp1_pronto = 1'b0;
      drive_req(1'b1, 1'b1, 3'b011, 32'd0, 32'd0, 1'b0);
      #1;
      chk("rr3_pronto", {bus1.req0_pronto, bus1.req1_pronto}, 2'b10);
      @(posedge clk);
      @(negedge clk);
      bus1.req0_valido = 1'b0;
      @(negedge clk);
      chk("rr3_resp", {bus1.resp0_valido, bus1.resp_saida}, {1'b1, 32'd12});

      // stalled response; resp1_pronto belongs to nobody and must be ignored
      bus1.resp1_pronto = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d", i),
             {bus1.resp0_valido, bus1.resp1_valido, bus1.req1_pronto, bus1.resp_saida},
             {3'b100, 32'd12});
      end
      bus1.resp1_pronto = 1'b0;
      bus1.resp0_pronto = 1'b1;
      @(negedge clk);
      bus1.resp0_pronto = 1'b0;
      chk("stall_fim", {bus1.ocupado, bus1.resp0_valido, bus1.req1_pronto}, 3'b001);
      @(posedge clk);
      @(negedge clk);
      bus1.req1_valido = 1'b0;
      @(negedge clk);
      chk("stall_req1", {bus1.resp1_valido, bus1.resp_saida}, {1'b1, 32'hFFFFFFFF});
      bus1.resp1_pronto = 1'b1;
      @(negedge clk);
      bus1.resp1_pronto = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(tab[i], i);

      // ALU inputs keep the last operation; stray resp pronto while idle does nothing
      bus1.resp0_pronto = 1'b1;
      @(negedge clk);
      bus1.resp0_pronto = 1'b0;
      chk("ocioso_ula_mantida", {bus1.ula_controle, bus1.ula_a, bus1.ula_b}, {3'b111, 32'hFFFFFFFF, 32'd1});
      chk("ocioso_pronto_ignorado", {bus1.ocupado, bus1.resp0_valido}, 0);

      // CICLOS_ULA=3: SLT held three cycles, result after exactly three
      @(negedge clk);
      bus3.req0_valido = 1'b1; bus3.req0_op = 3'b111;
      bus3.req0_a = 32'hFFFFFFFF; bus3.req0_b = 32'd1; bus3.req0_cin = 1'b0;
      #1;
      chk("c3_pronto", bus3.req0_pronto, 1);
      @(posedge clk);
      @(negedge clk);
      bus3.req0_valido = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("c3_exec%0d", i),
             {bus3.ocupado, bus3.resp0_valido, bus3.ula_controle, bus3.ula_a, bus3.ula_b},
             {2'b10, 3'b111, 32'hFFFFFFFF, 32'd1});
      end
      @(negedge clk);
      chk("c3_resp", {bus3.resp0_valido, bus3.resp_saida, bus3.resp_zero}, {1'b1, 32'd1, 1'b0});
      bus3.resp0_pronto = 1'b1;
      @(negedge clk);
      bus3.resp0_pronto = 1'b0;

      // reset mid-EXECUTA on the 3-cycle instance; pointer favoured req1 before it
      bus3.req1_valido = 1'b1; bus3.req1_op = 3'b010;
      bus3.req1_a = 32'd2; bus3.req1_b = 32'd3;
      #1;
      chk("c3_rr_pronto1", bus3.req1_pronto, 1);
      @(posedge clk);
      @(negedge clk);
      bus3.req1_valido = 1'b0;
      chk("c3_aborta_antes", bus3.ocupado, 1);
      rst3_n = 1'b0;
      #1;
      chk("c3_aborta_reset", {bus3.ocupado, bus3.resp0_valido, bus3.resp1_valido, bus3.ula_a}, 0);
      @(negedge clk);
      rst3_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("c3_sem_resp%0d", i), {bus3.ocupado, bus3.resp1_valido}, 0);
      end
      bus3.req0_valido = 1'b1;
      bus3.req1_valido = 1'b1;
      #1;
      chk("c3_ptr_reset", {bus3.req0_pronto, bus3.req1_pronto}, 2'b10);
      bus3.req0_valido = 1'b0;
      bus3.req1_valido = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
